// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA mode table, sync bundle type and timing helpers for vga_timing_gen.
package vga_timing_pkg;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
      int unsigned clk_div;
      logic        hs_pol;
      logic        vs_pol;
   } vga_mode_t;

   // Pixel-clock divide ratios assume a 100 MHz board clock.
   localparam vga_mode_t MODE_640X480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      clk_div: 4, hs_pol: 1'b0, vs_pol: 1'b0
   };

   localparam vga_mode_t MODE_800X600_72 = '{
      h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
      v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
      clk_div: 2, hs_pol: 1'b1, vs_pol: 1'b1
   };

   typedef struct packed {
      logic hs;
      logic vs;
      logic von;
   } sync_t;

   function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_tick_div.sv
// Clock-enable divider: one registered pixel tick every CLK_DIV enabled clocks.
module vga_tick_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned     DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      div_d  = div_q;
      tick_d = tick_q;
      if (en) begin
         tick_d = (div_q == DIV_MAX);
         div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   // A held tick survives an en-low stretch and fires on release, so no pixel period is lost.
   assign tick = tick_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, sync decode, strobes and a
// pixel-tick-aligned delay line that keeps syncs in step with a pipelined pixel generator.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = MODE_640X480_60.h_active,
   parameter int unsigned H_FP     = MODE_640X480_60.h_fp,
   parameter int unsigned H_SYNC   = MODE_640X480_60.h_sync,
   parameter int unsigned H_BP     = MODE_640X480_60.h_bp,
   parameter int unsigned V_ACTIVE = MODE_640X480_60.v_active,
   parameter int unsigned V_FP     = MODE_640X480_60.v_fp,
   parameter int unsigned V_SYNC   = MODE_640X480_60.v_sync,
   parameter int unsigned V_BP     = MODE_640X480_60.v_bp,
   parameter logic        HS_POL   = MODE_640X480_60.hs_pol,
   parameter logic        VS_POL   = MODE_640X480_60.vs_pol,
   parameter int unsigned CLK_DIV  = MODE_640X480_60.clk_div,
   parameter int unsigned PIPE_DLY = 0,
   parameter int unsigned CW       = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          pixel_tick,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          video_on,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned   H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned   V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned   HS_START = H_ACTIVE + H_FP;
   localparam int unsigned   HS_END   = HS_START + H_SYNC;
   localparam int unsigned   VS_START = V_ACTIVE + V_FP;
   localparam int unsigned   VS_END   = VS_START + V_SYNC;
   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   localparam sync_t         SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, von: 1'b0};

   if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW) || CLK_DIV == 0 || PIPE_DLY > 7) begin : g_param_check
      $fatal(1, "vga_timing_gen: illegal parameter set");
   end

   logic tick;

   vga_tick_div #(
      .CLK_DIV(CLK_DIV)
   ) u_tick_div (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .tick(tick)
   );

   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic          x_last, y_last;

   assign x_last = (x_q == X_LAST);
   assign y_last = (y_q == Y_LAST);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Decode in 32 bits so a sync window ending exactly at 2^CW still compares correctly.
   sync_t raw, tap, out_q, out_d;

   always_comb begin
      raw.hs  = (32'(x_q) >= HS_START && 32'(x_q) < HS_END) ? HS_POL : ~HS_POL;
      raw.vs  = (32'(y_q) >= VS_START && 32'(y_q) < VS_END) ? VS_POL : ~VS_POL;
      raw.von = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
   end

   if (PIPE_DLY == 0) begin : g_no_dly
      assign tap = raw;
   end else begin : g_dly
      sync_t dly_q [PIPE_DLY];
      sync_t dly_d [PIPE_DLY];

      always_comb begin
         dly_d = dly_q;
         if (tick) begin
            dly_d[0] = raw;
            for (int unsigned i = 1; i < PIPE_DLY; i++) begin
               dly_d[i] = dly_q[i-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         // NOTE: this small shift register is reset so syncs come out inactive until real data reaches the tap.
         if (rst) begin
            for (int unsigned i = 0; i < PIPE_DLY; i++) begin
               dly_q[i] <= SYNC_IDLE;
            end
         end else begin
            dly_q <= dly_d;
         end
      end

      assign tap = dly_q[PIPE_DLY-1];
   end

   assign out_d = en ? tap : out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= SYNC_IDLE;
      end else begin
         out_q <= out_d;
      end
   end

   assign pixel_tick  = tick;
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = out_q.hs;
   assign vsync       = out_q.vs;
   assign video_on    = out_q.von;
   assign line_start  = tick && x_last;
   assign frame_start = tick && x_last && y_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: a default 640x480 instance and a tiny pipelined
// instance, both compared every clock against a closed-form timing model.
module tb_vga_timing_gen;

   typedef struct packed {
      int unsigned ha, hf, hsw, hb, va, vf, vsw, vb, d, dly;
      logic        hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic        tick;
      logic [10:0] x;
      logic [10:0] y;
      logic        von, hs, vs, ls, fs;
   } obs_t;

   localparam cfg_t CFG_A = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33,
                              d: 4, dly: 0, hpol: 1'b0, vpol: 1'b0};
   localparam cfg_t CFG_B = '{ha: 4, hf: 1, hsw: 2, hb: 1, va: 2, vf: 1, vsw: 1, vb: 1,
                              d: 1, dly: 3, hpol: 1'b1, vpol: 1'b0};
   localparam int unsigned N_CYCLES = 40000;

   logic        clk;
   logic        rst_a, en_a, rst_b, en_b;
   logic        pt_a, von_a, hs_a, vs_a, ls_a, fs_a;
   logic [10:0] x_a, y_a;
   logic        pt_b, von_b, hs_b, vs_b, ls_b, fs_b;
   logic [2:0]  x_b, y_b;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .pixel_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
      .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hf), .H_SYNC(CFG_B.hsw), .H_BP(CFG_B.hb),
      .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vf), .V_SYNC(CFG_B.vsw), .V_BP(CFG_B.vb),
      .HS_POL(CFG_B.hpol), .VS_POL(CFG_B.vpol), .CLK_DIV(CFG_B.d), .PIPE_DLY(CFG_B.dly), .CW(3)
   ) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .pixel_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
      .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, got, exp);
      end
   endtask

   // Pixel updates completed after n enabled clocks since reset.
   function automatic int unsigned pix(input int unsigned n, input int unsigned d);
      return (n == 0) ? 0 : (n - 1) / d;
   endfunction

   // Outputs after n enabled clocks since reset, with en as currently driven.
   function automatic obs_t model(input cfg_t c, input int unsigned n, input logic en);
      int unsigned ht = c.ha + c.hf + c.hsw + c.hb;
      int unsigned vt = c.va + c.vf + c.vsw + c.vb;
      int unsigned p  = pix(n, c.d);
      int unsigned x  = p % ht;
      int unsigned y  = (p / ht) % vt;
      int unsigned q, qx, qy;
      obs_t o;
      o.tick = en && (n != 0) && ((n % c.d) == 0);
      o.x    = 11'(x);
      o.y    = 11'(y);
      o.ls   = o.tick && (x == ht - 1);
      o.fs   = o.ls && (y == vt - 1);
      o.hs   = ~c.hpol;
      o.vs   = ~c.vpol;
      o.von  = 1'b0;
      if (n != 0 && pix(n - 1, c.d) >= c.dly) begin
         q     = pix(n - 1, c.d) - c.dly;
         qx    = q % ht;
         qy    = (q / ht) % vt;
         o.von = (qx < c.ha) && (qy < c.va);
         o.hs  = (qx >= c.ha + c.hf && qx < c.ha + c.hf + c.hsw) ? c.hpol : ~c.hpol;
         o.vs  = (qy >= c.va + c.vf && qy < c.va + c.vf + c.vsw) ? c.vpol : ~c.vpol;
      end
      return o;
   endfunction

   obs_t        qa[$];
   obs_t        qb[$];
   int unsigned a_lines = 0;
   int unsigned b_frames = 0;

   // Stimulus: advance the model for the edge just taken, pick new inputs, queue expectations.
   initial begin
      int unsigned na = 0, nb = 0, freeze_left = 0;
      bit          froze = 0, b_reset_done = 0;
      rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         na = rst_a ? 0 : (en_a ? na + 1 : na);
         nb = rst_b ? 0 : (en_b ? nb + 1 : nb);

         rst_a = (cyc < 2);
         if (freeze_left != 0) begin
            en_a = 1'b0;
            freeze_left--;
         end else if (!froze && cyc > 10000 && (pix(na, CFG_A.d) % 800) == 300) begin
            en_a = 1'b0;
            freeze_left = 99;
            froze = 1;
         end else if (cyc > 14000) begin
            en_a  = ($urandom_range(15) != 0);
            rst_a = ($urandom_range(4999) == 0);
         end else begin
            en_a = 1'b1;
         end

         rst_b = (cyc < 2);
         if (!b_reset_done && cyc > 400 && (pix(nb, 1) % 8) == 6 && ((pix(nb, 1) / 8) % 5) == 3) begin
            rst_b = 1'b1;
            b_reset_done = 1;
         end else if (cyc > 200) begin
            en_b  = ($urandom_range(7) != 0);
            rst_b = ($urandom_range(2999) == 0);
         end

         qa.push_back(model(CFG_A, na, en_a));
         qb.push_back(model(CFG_B, nb, en_b));
      end
      repeat (2) @(posedge clk);
      check("a_queue_drained", 64'(qa.size()), 0);
      check("b_queue_drained", 64'(qb.size()), 0);
      check("a_lines_checked", 64'(a_lines >= 8), 1);
      check("b_frames_checked", 64'(b_frames >= 100), 1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Monitor: compare every presented cycle and measure per-line / per-frame totals.
   initial begin
      obs_t        ga, gb, ea, eb;
      int unsigned a_ticks = 0, a_hs_low = 0, b_cnt = 0, b_von = 0;
      bit          a_line_ok = 0, b_frame_ok = 0;
      forever begin
         @(negedge clk);
         if (qa.size() != 0) begin
            ea = qa.pop_front();
            ga = '{tick: pt_a, x: x_a, y: y_a, von: von_a, hs: hs_a, vs: vs_a, ls: ls_a, fs: fs_a};
            check("a_outputs", 64'(ga), 64'(ea));
            if (rst_a) begin
               a_ticks = 0; a_hs_low = 0; a_line_ok = 1;
            end else if (ga.tick) begin
               a_ticks++;
               if (ga.hs == CFG_A.hpol) a_hs_low++;
               if (ga.ls) begin
                  if (a_line_ok) begin
                     check("a_line_ticks", 64'(a_ticks), 800);
                     check("a_hsync_low_ticks", 64'(a_hs_low), 96);
                     a_lines++;
                  end
                  a_ticks = 0; a_hs_low = 0; a_line_ok = 1;
               end
            end
         end
         if (qb.size() != 0) begin
            eb = qb.pop_front();
            gb = '{tick: pt_b, x: 11'(x_b), y: 11'(y_b), von: von_b, hs: hs_b, vs: vs_b,
                   ls: ls_b, fs: fs_b};
            check("b_outputs", 64'(gb), 64'(eb));
            if (rst_b) begin
               b_cnt = 0; b_von = 0; b_frame_ok = 0;
            end else if (en_b) begin
               b_cnt++;
               if (gb.von) b_von++;
               if (gb.fs) begin
                  if (b_frame_ok) begin
                     check("b_frame_clks", 64'(b_cnt), 40);
                     check("b_video_clks", 64'(b_von), 8);
                     b_frames++;
                  end
                  b_cnt = 0; b_von = 0; b_frame_ok = 1;
               end
            end
         end
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. It replaces the fixed 640x480 sync stage between the board clock and the graphic generator. Resolution, porches, sync polarity and the pixel-clock divide ratio are all parameters. It also adds a run-enable input, line and frame strobes, and a programmable sync delay so hsync/vsync/video_on stay aligned with a pipelined pixel generator.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CLK_DIV, 4, clk cycles per pixel (>=1); 100 MHz/4 = 25 MHz
PIPE_DLY, 0, pixel ticks of delay applied to hsync/vsync/video_on (0..7)
CW, 11, width of the pixel_x/pixel_y counters

Ports:
clk  in  1  board clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low freezes all timing state
pixel_tick  out  1  one-clk strobe marking each pixel period
pixel_x  out  CW  current horizontal count, 0..H_TOTAL-1
pixel_y  out  CW  current vertical count, 0..V_TOTAL-1
video_on  out  1  pixel inside the active area (delayed by PIPE_DLY)
hsync  out  1  horizontal sync (delayed by PIPE_DLY)
vsync  out  1  vertical sync (delayed by PIPE_DLY)
line_start  out  1  one-clk pulse: pixel_x about to wrap to 0
frame_start  out  1  one-clk pulse: (x,y) about to wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default).
- Reset (rst=1 at a clk edge) sets:
  - divider, pixel_x and pixel_y to 0;
  - pixel_tick, line_start, frame_start and video_on to 0;
  - hsync to ~HS_POL and vsync to ~VS_POL (inactive);
  - the delay line to the inactive values.
- Reset has priority over en. Reset mid-frame restarts at (0,0) on the next cycle, with no partial strobes.
- Divider:
  - counts 0..CLK_DIV-1 while en=1;
  - pixel_tick is registered and is high for exactly one clk on the cycle after the divider reaches CLK_DIV-1;
  - with CLK_DIV=1, pixel_tick is high every cycle while en=1.
- Counters advance only on cycles where pixel_tick=1:
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments;
  - pixel_y wraps from V_TOTAL-1 to 0.
- line_start equals pixel_tick AND pixel_x=H_TOTAL-1. frame_start additionally requires pixel_y=V_TOTAL-1.
- Raw sync terms are combinational from the current counters:
  - raw_hs = HS_POL when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL;
  - raw_vs is the same form on pixel_y with the V_* parameters;
  - raw_von = (pixel_x < H_ACTIVE) AND (pixel_y < V_ACTIVE).
- Delay line:
  - raw terms pass through a PIPE_DLY-stage shift register that shifts only on pixel_tick, then a final output register;
  - PIPE_DLY=0 means the output register only, i.e. one clk after the counter update.
- en low: divider, counters and the delay line hold; strobes are forced to 0; sync levels hold.
- Width rule: an elaboration-time check fails if H_TOTAL or V_TOTAL exceeds 2^CW, or if CLK_DIV is 0.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constants for 640x480@60 (div 4 from 100 MHz) and 800x600@72 (div 2: 800/56/120/64, 600/37/6/23, active-high syncs);
  - a function computing total from active+fp+sync+bp.
- One sub-module: vga_tick_div, the parametrised clock-enable divider with en and rst, producing pixel_tick.

Test Plan:
- Default params, rst high for 3 clks, then en=1:
  - every output holds its reset value while rst is high;
  - the first pixel_tick appears 4 clks after rst falls;
  - ticks recur every 4 clks.
- Default params, run one line: hsync is low for exactly 96 ticks, pixel_x 656..751 (shifted one clk by the output register); line_start pulses once per 800 ticks.
- Default params, run one frame:
  - vsync is low on lines 490..491;
  - video_on is high for 640x480 = 307200 ticks;
  - frame_start fires every 1,680,000 clks.
- CLK_DIV=1, H_ACTIVE=4/FP=1/SYNC=2/BP=1, V_ACTIVE=2/1/1/1, PIPE_DLY=3: hsync edges lag the raw decode by exactly 3 ticks + 1 clk; the frame length is 8x5 = 40 clks.
- en held low for 100 clks mid-line at pixel_x=300: pixel_x stays 300, no strobes occur, sync levels hold; the count resumes at 301 on release.
- rst asserted for 1 clk at pixel_x=700, pixel_y=491: the next cycle shows (0,0), syncs inactive, no frame_start pulse.
